// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS ID stage.
//   - opcode / funct constants for the supported instruction subset
//   - ALU operation encoding seen by EX
//   - destination-register select and the packed control bundle
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_RD   = 2'd1,
        DST_RT   = 2'd2
    } dst_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    branch;
        alu_op_e alu_op;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: purely combinational main/ALU control decoder.
// Ports:
//   opcode, funct  in  instruction fields [31:26] and [5:0]
//   is_nop         in  the whole instruction word is zero
//   ctrl           out control bits, ALU op and illegal flag
//   uses_rs/rt     out instruction actually reads rs / rt (for hazard detection)
//   dst_sel        out which field (if any) names the destination register
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       is_nop,
    output ctrl_t      ctrl,
    output logic       uses_rs,
    output logic       uses_rt,
    output dst_sel_e   dst_sel
);

    always_comb begin
        ctrl    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        dst_sel = DST_NONE;

        unique case (opcode)
            OP_RTYPE: begin
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
                dst_sel        = DST_RD;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: begin
                        // Unsupported funct: kill everything. The all-zero
                        // word (sll $0,$0,0) is the canonical NOP, not illegal.
                        ctrl    = '0;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                        dst_sel = DST_NONE;
                        ctrl.illegal = !is_nop;
                    end
                endcase
            end
            OP_LW: begin
                uses_rs         = 1'b1;
                dst_sel         = DST_RT;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                uses_rs        = 1'b1;
                dst_sel        = DST_RT;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS instruction decode plus ID/EX pipeline register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_valid/id_instr/id_pc4       IF/ID contents
//   flush                          branch taken in EX, squash ID
//   rf_readA/B, rf_A/B             register-bank read port (address out, data in)
//   wb_regWrite/wb_write/wb_data   write-back port, bypassed into the operands
//   stall                          load-use hazard, hold PC and IF/ID
//   ex_*                           registered operands and controls for EX
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_instr,
    input  logic [XLEN-1:0]  id_pc4,
    input  logic             flush,
    output logic [RADDR-1:0] rf_readA,
    output logic [RADDR-1:0] rf_readB,
    input  logic [XLEN-1:0]  rf_A,
    input  logic [XLEN-1:0]  rf_B,
    input  logic             wb_regWrite,
    input  logic [RADDR-1:0] wb_write,
    input  logic [XLEN-1:0]  wb_data,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_A,
    output logic [XLEN-1:0]  ex_B,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc4,
    output logic [RADDR-1:0] ex_rs,
    output logic [RADDR-1:0] ex_rt,
    output logic [RADDR-1:0] ex_dst,
    output logic             ex_regWrite,
    output logic             ex_memRead,
    output logic             ex_memWrite,
    output logic             ex_memToReg,
    output logic             ex_aluSrc,
    output logic             ex_branch,
    output logic [2:0]       ex_aluOp,
    output logic             ex_illegal
);

    logic [RADDR-1:0] rs, rt, rd, dst;
    logic [XLEN-1:0]  opa, opb, imm;
    ctrl_t            ctrl;
    logic             uses_rs, uses_rt, hazard;
    dst_sel_e         dst_sel;

    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [XLEN-1:0]  ex_imm_q, ex_imm_d, ex_pc4_q, ex_pc4_d;
    logic [RADDR-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dst_q, ex_dst_d;
    ctrl_t            ex_ctrl_q, ex_ctrl_d;

    assign rs  = id_instr[25:21];
    assign rt  = id_instr[20:16];
    assign rd  = id_instr[15:11];
    assign imm = {{(XLEN-16){id_instr[15]}}, id_instr[15:0]};

    assign rf_readA = rs;
    assign rf_readB = rt;

    mips_ctrl_decode u_decode (
        .opcode  (id_instr[31:26]),
        .funct   (id_instr[5:0]),
        .is_nop  (id_instr == '0),
        .ctrl    (ctrl),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .dst_sel (dst_sel)
    );

    always_comb begin
        dst = '0;
        case (dst_sel)
            DST_RD:  dst = rd;
            DST_RT:  dst = rt;
            default: dst = '0;
        endcase
    end

    // Operand select: the bank does not hardwire $0, and it writes at the
    // edge, so a same-cycle write-back must be bypassed past its stale read.
    always_comb begin
        opa = rf_A;
        if (rs == '0)                         opa = '0;
        else if (wb_regWrite && wb_write == rs) opa = wb_data;

        opb = rf_B;
        if (rt == '0)                         opb = '0;
        else if (wb_regWrite && wb_write == rt) opb = wb_data;
    end

    assign hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_dst_q != '0) && id_valid &&
                    ((uses_rs && ex_dst_q == rs) || (uses_rt && ex_dst_q == rt));

    // A wrong-path instruction is being squashed anyway, so it never stalls.
    assign stall = hazard && !flush;

    always_comb begin
        ex_valid_d = 1'b0;
        ex_a_d     = '0;
        ex_b_d     = '0;
        ex_imm_d   = '0;
        ex_pc4_d   = '0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        ex_dst_d   = '0;
        ex_ctrl_d  = '0;
        if (!(flush || hazard)) begin
            ex_valid_d = id_valid;
            ex_a_d     = opa;
            ex_b_d     = opb;
            ex_imm_d   = imm;
            ex_pc4_d   = id_pc4;
            ex_rs_d    = rs;
            ex_rt_d    = rt;
            ex_dst_d   = dst;
            ex_ctrl_d  = id_valid ? ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_pc4_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_dst_q   <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_pc4_q   <= ex_pc4_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_dst_q   <= ex_dst_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_A        = ex_a_q;
    assign ex_B        = ex_b_q;
    assign ex_imm      = ex_imm_q;
    assign ex_pc4      = ex_pc4_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_dst      = ex_dst_q;
    assign ex_regWrite = ex_ctrl_q.reg_write;
    assign ex_memRead  = ex_ctrl_q.mem_read;
    assign ex_memWrite = ex_ctrl_q.mem_write;
    assign ex_memToReg = ex_ctrl_q.mem_to_reg;
    assign ex_aluSrc   = ex_ctrl_q.alu_src;
    assign ex_branch   = ex_ctrl_q.branch;
    assign ex_aluOp    = ex_ctrl_q.alu_op;
    assign ex_illegal  = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of decode, operand select, load-use
// stall, flush, illegal decode and reset for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr, id_pc4;
    logic        flush;
    logic [4:0]  rf_readA, rf_readB;
    logic [31:0] rf_A, rf_B;
    logic        wb_regWrite;
    logic [4:0]  wb_write;
    logic [31:0] wb_data;
    logic        stall, ex_valid;
    logic [31:0] ex_A, ex_B, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch;
    logic [2:0]  ex_aluOp;
    logic        ex_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // {regWrite,memRead,memWrite,memToReg,aluSrc,branch,aluOp[2:0],illegal}
    logic [9:0] ctrl;
    assign ctrl = {ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc,
                   ex_branch, ex_aluOp, ex_illegal};

    localparam logic [9:0] C_ZERO = 10'b0000000000;
    localparam logic [9:0] C_ADD  = 10'b1000000000;
    localparam logic [9:0] C_LW   = 10'b1101100000;
    localparam logic [9:0] C_SW   = 10'b0010100000;
    localparam logic [9:0] C_BEQ  = 10'b0000010010;
    localparam logic [9:0] C_ILL  = 10'b0000000001;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
        .flush(flush), .rf_readA(rf_readA), .rf_readB(rf_readB), .rf_A(rf_A), .rf_B(rf_B),
        .wb_regWrite(wb_regWrite), .wb_write(wb_write), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_regWrite(ex_regWrite),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
        .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch), .ex_aluOp(ex_aluOp),
        .ex_illegal(ex_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one ID-stage instruction; inputs change 1 time unit after the edge.
    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b);
        id_valid = v;
        id_instr = instr;
        rf_A     = a;
        rf_B     = b;
        id_pc4   = instr ^ 32'h0000_1000;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        wb_regWrite = 1'b0; wb_write = '0; wb_data = '0;
        drive(1'b1, 32'h00221820, 32'd6, 32'd7);
        tick; tick;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ctrl",  {22'd0, ctrl}, {22'd0, C_ZERO});
        chk("rst_data",  ex_A | ex_B | ex_imm | ex_pc4, 32'd0);
        chk("rst_regs",  {17'd0, ex_rs, ex_rt, ex_dst}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // add $3,$1,$2
        rst = 1'b0;
        #1;
        chk("add_rdaddr", {22'd0, rf_readA, rf_readB}, {22'd0, 5'd1, 5'd2});
        tick;
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_A",   ex_A, 32'd6);
        chk("add_B",   ex_B, 32'd7);
        chk("add_dst", {27'd0, ex_dst}, 32'd3);
        chk("add_rsrt", {22'd0, ex_rs, ex_rt}, {22'd0, 5'd1, 5'd2});
        chk("add_ctrl", {22'd0, ctrl}, {22'd0, C_ADD});
        chk("add_imm", ex_imm, 32'h0000_1820);
        chk("add_pc4", ex_pc4, 32'h0022_0820);

        // add $4,$0,$2 : $0 forced regardless of bank data
        drive(1'b1, 32'h00022020, 32'd5, 32'd9);
        tick;
        chk("zero_A", ex_A, 32'd0);
        chk("zero_B", ex_B, 32'd9);
        chk("zero_dst", {27'd0, ex_dst}, 32'd4);

        // WB bypass on A
        drive(1'b1, 32'h00221820, 32'd6, 32'd7);
        wb_regWrite = 1'b1; wb_write = 5'd1; wb_data = 32'hDEADBEEF;
        tick;
        chk("byp_A", ex_A, 32'hDEADBEEF);
        chk("byp_A_B", ex_B, 32'd7);
        // WB bypass on B
        wb_write = 5'd2;
        tick;
        chk("byp_B_A", ex_A, 32'd6);
        chk("byp_B", ex_B, 32'hDEADBEEF);
        // write to $0 must not beat the forcing
        drive(1'b1, 32'h00022020, 32'd5, 32'd9);
        wb_write = 5'd0; wb_data = 32'h55;
        tick;
        chk("byp_zero_A", ex_A, 32'd0);
        // matching address but write disabled
        drive(1'b1, 32'h00221820, 32'd6, 32'd7);
        wb_regWrite = 1'b0; wb_write = 5'd1;
        tick;
        chk("byp_off_A", ex_A, 32'd6);

        // load-use: lw $2,-4($1) then add $3,$2,$1
        drive(1'b1, 32'h8C22FFFC, 32'h100, 32'd0);
        tick;
        chk("lw_imm", ex_imm, 32'hFFFFFFFC);
        chk("lw_ctrl", {22'd0, ctrl}, {22'd0, C_LW});
        chk("lw_dst", {27'd0, ex_dst}, 32'd2);
        chk("lw_A", ex_A, 32'h100);
        drive(1'b1, 32'h00411820, 32'd11, 32'd22);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick;
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_ctrl", {22'd0, ctrl}, {22'd0, C_ZERO});
        chk("lu_bubble_data", ex_A | ex_B | {27'd0, ex_dst}, 32'd0);
        chk("lu_restall", {31'd0, stall}, 32'd0);
        tick;
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_A", ex_A, 32'd11);
        chk("lu_add_dst", {27'd0, ex_dst}, 32'd3);

        // load-use through rt only: lw $2 then sw $2,0($1)
        drive(1'b1, 32'h8C22FFFC, 32'h100, 32'd0);
        tick;
        drive(1'b1, 32'hAC220000, 32'h200, 32'd33);
        #1;
        chk("lu_rt_stall", {31'd0, stall}, 32'd1);
        tick;
        tick;
        chk("sw_ctrl", {22'd0, ctrl}, {22'd0, C_SW});
        chk("sw_dst", {27'd0, ex_dst}, 32'd0);
        chk("sw_B", ex_B, 32'd33);

        // lw $2 then addi $2,$3,1: rt is a destination, not a use
        drive(1'b1, 32'h8C22FFFC, 32'h100, 32'd0);
        tick;
        drive(1'b1, 32'h20620001, 32'd4, 32'd0);
        #1;
        chk("addi_nostall", {31'd0, stall}, 32'd0);
        tick;
        chk("addi_ctrl", {22'd0, ctrl}, {22'd0, 10'b1000100000});
        chk("addi_dst", {27'd0, ex_dst}, 32'd2);

        // flush + hazard
        drive(1'b1, 32'h8C22FFFC, 32'h100, 32'd0);
        tick;
        drive(1'b1, 32'h00411820, 32'd11, 32'd22);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, stall}, 32'd0);
        tick;
        flush = 1'b0;
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_ctrl", {22'd0, ctrl}, {22'd0, C_ZERO});

        // beq $1,$2,3
        drive(1'b1, 32'h10220003, 32'd1, 32'd2);
        tick;
        chk("beq_ctrl", {22'd0, ctrl}, {22'd0, C_BEQ});
        chk("beq_dst", {27'd0, ex_dst}, 32'd0);

        // illegal opcode and illegal funct
        drive(1'b1, 32'hFC000000, 32'd0, 32'd0);
        tick;
        chk("ill_op", {22'd0, ctrl}, {22'd0, C_ILL});
        chk("ill_op_valid", {31'd0, ex_valid}, 32'd1);
        drive(1'b1, 32'h00221821, 32'd6, 32'd7);
        tick;
        chk("ill_fn", {22'd0, ctrl}, {22'd0, C_ILL});

        // NOP word is not illegal
        drive(1'b1, 32'h00000000, 32'd0, 32'd0);
        tick;
        chk("nop_ctrl", {22'd0, ctrl}, {22'd0, C_ZERO});
        chk("nop_valid", {31'd0, ex_valid}, 32'd1);

        // invalid slot: controls forced off
        drive(1'b0, 32'h00221820, 32'd6, 32'd7);
        tick;
        chk("inv_valid", {31'd0, ex_valid}, 32'd0);
        chk("inv_ctrl", {22'd0, ctrl}, {22'd0, C_ZERO});

        // reset in the middle of a stall
        drive(1'b1, 32'h8C22FFFC, 32'h100, 32'd0);
        tick;
        drive(1'b1, 32'h00411820, 32'd11, 32'd22);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rs_mid_valid", {31'd0, ex_valid}, 32'd0);
        chk("rs_mid_ctrl", {22'd0, ctrl}, {22'd0, C_ZERO});
        chk("rs_mid_regs", {17'd0, ex_rs, ex_rt, ex_dst}, 32'd0);
        chk("rs_mid_stall", {31'd0, stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Instruction-decode stage plus ID/EX pipeline register of the 5-stage MIPS pipeline.
- Decodes the IF/ID instruction and drives the register-bank read addresses.
- Captures the bank's A/B outputs with $0 forcing and same-cycle write-back bypass, and detects load-use hazards.
- Registers all operands and control bits for EX.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  XLEN  IF/ID instruction word.
- id_pc4  in  XLEN  IF/ID PC+4.
- flush  in  1  branch taken in EX; squash the instruction in ID.
- rf_readA  out  RADDR  bank read address A; equals instr[25:21], combinational.
- rf_readB  out  RADDR  bank read address B; equals instr[20:16], combinational.
- rf_A  in  XLEN  bank read data A.
- rf_B  in  XLEN  bank read data B.
- wb_regWrite  in  1  WB write enable, same signal as the bank's regWrite.
- wb_write  in  RADDR  WB destination.
- wb_data  in  XLEN  WB data.
- stall  out  1  hold PC and IF/ID this cycle; combinational.
- ex_valid  out  1  EX holds a real instruction.
- ex_A  out  XLEN  registered operand A.
- ex_B  out  XLEN  registered operand B.
- ex_imm  out  XLEN  registered sign-extended imm16.
- ex_pc4  out  XLEN  registered PC+4.
- ex_rs  out  RADDR  source register number, for the EX forwarding unit.
- ex_rt  out  RADDR  source register number, for the EX forwarding unit.
- ex_dst  out  RADDR  destination register; 0 if none.
- ex_regWrite  out  1  registered control bit.
- ex_memRead  out  1  registered control bit.
- ex_memWrite  out  1  registered control bit.
- ex_memToReg  out  1  registered control bit.
- ex_aluSrc  out  1  registered control bit.
- ex_branch  out  1  registered control bit.
- ex_aluOp  out  3  0=ADD 1=SUB 2=AND 3=OR 4=SLT.
- ex_illegal  out  1  unsupported opcode/funct decoded.

Behaviour:
- Decode:
  - R-type (op 0x00): funct 0x20/0x22/0x24/0x25/0x2A give ADD/SUB/AND/OR/SLT; dst=rd; regWrite=1; uses rs and rt.
  - lw (0x23): ADD, aluSrc, memRead, memToReg, regWrite; dst=rt; uses rs.
  - sw (0x2B): ADD, aluSrc, memWrite; dst=0; uses rs and rt.
  - beq (0x04): SUB, branch; dst=0; uses rs and rt.
  - addi (0x08): ADD, aluSrc, regWrite; dst=rt; uses rs.
  - Anything else: all controls 0, dst=0, illegal=1. The word 0x00000000 is a NOP: all controls 0, illegal=0.
- Immediate: sign-extend instr[15:0] to XLEN.
- Operand select for A (B identical with rt/rf_B), in priority order:
  - rs==0 gives 0. The bank does not hardwire $0, so this forcing is mandatory.
  - Else wb_regWrite && wb_write==rs gives wb_data. The bank writes at the edge, so its combinational read is stale this cycle.
  - Else rf_A.
- Load-use hazard: ex_valid && ex_memRead && ex_dst!=0 && id_valid && ((uses_rs && ex_dst==rs) || (uses_rt && ex_dst==rt)).
- stall = hazard && !flush. A wrong-path instruction never stalls.
- ID/EX register update at posedge, in priority order:
  1. rst: every ex_* output becomes 0.
  2. flush or hazard: bubble. ex_valid and all control bits go to 0; data and register fields also go to 0.
  3. Otherwise: load decoded values; ex_valid=id_valid. If id_valid=0, controls are forced to 0.
- Latency: one cycle, ID to ex_*.
- A stalled instruction is re-decoded next cycle and re-reads the bank.
- Reset mid-stall: rst wins; stall is don't-care while rst is high.
- ex_rs/ex_rt carry raw fields, including 0, even for formats that do not use them.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT.
  - aluOp encodings ALU_ADD..ALU_SLT.
- One sub-module: mips_ctrl_decode. It is purely combinational: opcode/funct in; control bits, aluOp, uses_rs, uses_rt, dst select and illegal out. The bypass, hazard and pipeline register stay in id_ex_stage.

Test Plan:
- Reset: hold rst 2 cycles with id_instr=0x00221820 -> all ex_* = 0 and stall=0.
- add $3,$1,$2 (0x00221820), rf_A=6, rf_B=7, id_valid=1 -> next cycle:
  - ex_A=6, ex_B=7, ex_dst=3, ex_aluOp=0, ex_regWrite=1, ex_valid=1.
- $0 forcing: add $4,$0,$2 (0x00022020), rf_A=5 -> ex_A=0.
- WB bypass: instr 0x00221820, wb_regWrite=1, wb_write=1, wb_data=0xDEADBEEF, rf_A=6 -> ex_A=0xDEADBEEF.
- Load-use:
  - Cycle 0: issue lw $2,-4($1) (0x8C22FFFC). Next cycle ex_imm=0xFFFFFFFC, ex_memRead=1, ex_dst=2.
  - Cycle 1: id_instr=add $3,$2,$1 (0x00411820) -> stall=1. At the following edge ex_valid=0 and all controls 0.
  - Cycle 2: stall=0 and the add loads normally.
- Flush+hazard: repeat the load-use setup with flush=1 in cycle 1 -> stall=0, and next cycle ex_valid=0.
- Illegal: id_instr=0xFC000000 -> ex_illegal=1 and all controls 0.
